// File: rtl/mem_stage.sv
// mem_stage: resolves branches, runs the data-memory req/ack handshake
// and builds the MEM/WB word for write-back.
module mem_stage #(
  parameter int N       = 24,
  parameter int BW      = 16 + 2 * N,
  parameter int WB_W    = 6 + 2 * N,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            flush,
  input  logic [BW-1:0]   exMem,
  input  logic [N-1:0]    memRdata,
  input  logic            memAck,
  output logic            memReq,
  output logic            memWe,
  output logic [N-1:0]    memAddr,
  output logic [N-1:0]    memWdata,
  output logic            stall,
  output logic            branchTaken,
  output logic [N-1:0]    branchTarget,
  output logic            memError,
  output logic [WB_W-1:0] memWb
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int HW = 3 + 2 * N + 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // EX/MEM word: {opType, opCode, zero, neg, branchFlag, memWrite,
  // memToReg, regWrite, aluResult, Rc[3:0], rd3}
  logic [1:0]   w_op;
  logic         w_zero;
  logic         w_neg;
  logic         w_bf;
  logic         w_mw;
  logic         w_mtr;
  logic         w_rw;
  logic [N-1:0] w_alu;
  logic [3:0]   w_rc;
  logic [N-1:0] w_rd3;
  logic         w_memop;
  logic         w_cond;
  logic         w_unused;

  assign w_op   = exMem[2*N+11:2*N+10];
  assign w_zero = exMem[2*N+9];
  assign w_neg  = exMem[2*N+8];
  assign w_bf   = exMem[2*N+7];
  assign w_mw   = exMem[2*N+6];
  assign w_mtr  = exMem[2*N+5];
  assign w_rw   = exMem[2*N+4];
  assign w_alu  = exMem[2*N+3:N+4];
  assign w_rc   = exMem[N+3:N];
  assign w_rd3  = exMem[N-1:0];
  assign w_unused = ^exMem[BW-1:2*N+12];

  assign w_memop = w_mw | w_mtr;

  // Held copy keeps only the fields an access needs.
  logic [HW-1:0] r_held;
  logic          h_mw;
  logic          h_mtr;
  logic          h_rw;
  logic [N-1:0]  h_alu;
  logic [3:0]    h_rc;
  logic [N-1:0]  h_rd3;

  assign h_mw  = r_held[HW-1];
  assign h_mtr = r_held[HW-2];
  assign h_rw  = r_held[HW-3];
  assign h_alu = r_held[2*N+3:N+4];
  assign h_rc  = r_held[N+3:N];
  assign h_rd3 = r_held[N-1:0];

  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CW-1:0]   w_cnt_inc;
  logic            r_squash;
  logic            w_sq_nxt;
  logic            w_sq;
  logic [N-1:0]    r_rdata;
  logic [N-1:0]    w_ld_data;
  logic [WB_W-1:0] r_wb;
  logic [WB_W-1:0] w_wb_nxt;
  logic            w_wb_we;
  logic            w_held_we;
  logic            w_rdata_we;
  logic            r_err;
  logic            w_err_set;

  assign w_sq      = r_squash | flush;
  assign w_ld_data = h_mw ? '0 : memRdata;
  assign w_cnt_inc = (r_cnt == CW'(TIMEOUT)) ? r_cnt
                                             : r_cnt + CW'(1);

  // Branch condition selected by opCode[1:0].
  always_comb begin
    w_cond = 1'b0;
    unique case (w_op)
      2'b00: w_cond = 1'b1;
      2'b01: w_cond = w_zero;
      2'b10: w_cond = ~w_zero;
      2'b11: w_cond = w_neg;
    endcase
  end

  // Next state, memory port drive and MEM/WB update selection.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sq_nxt    = w_sq;
    w_wb_we     = 1'b0;
    w_wb_nxt    = '0;
    w_held_we   = 1'b0;
    w_rdata_we  = 1'b0;
    w_err_set   = 1'b0;
    memReq      = 1'b0;
    stall       = 1'b0;
    branchTaken = 1'b0;
    memAddr     = h_alu;
    memWdata    = h_rd3;
    memWe       = h_mw;
    case (r_state)
      IDLE: begin
        memAddr     = w_alu;
        memWdata    = w_rd3;
        memWe       = w_mw;
        stall       = w_memop & ~flush;
        branchTaken = w_bf & w_cond & ~flush;
        w_sq_nxt    = 1'b0;
        if (en && w_memop && !flush) begin
          w_state_nxt = ACCESS;
          w_held_we   = 1'b1;
          w_cnt_nxt   = '0;
          w_wb_we     = 1'b1;
        end else if (en) begin
          w_wb_we  = 1'b1;
          w_wb_nxt = {w_rw & ~flush, w_mtr & ~flush,
                      w_rc, {N{1'b0}}, w_alu};
        end
      end
      ACCESS: begin
        memReq = 1'b1;
        stall  = 1'b1;
        if (memAck) begin
          if (en) begin
            stall       = 1'b0;
            w_state_nxt = IDLE;
            w_wb_we     = 1'b1;
            if (!w_sq)
              w_wb_nxt = {h_rw, h_mtr, h_rc, w_ld_data, h_alu};
          end else begin
            w_rdata_we  = 1'b1;
            w_state_nxt = DONE;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CW'(TIMEOUT)) begin
            w_err_set   = 1'b1;
            w_wb_we     = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      DONE: begin
        stall = 1'b1;
        if (en) begin
          stall       = 1'b0;
          w_state_nxt = IDLE;
          w_wb_we     = 1'b1;
          if (!w_sq)
            w_wb_nxt = {h_rw, h_mtr, h_rc, r_rdata, h_alu};
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, held copy, captured data, MEM/WB word and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_squash <= 1'b0;
      r_held   <= '0;
      r_rdata  <= '0;
      r_wb     <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_squash <= w_sq_nxt;
      if (w_held_we)
        r_held <= {w_mw, w_mtr, w_rw, w_alu, w_rc, w_rd3};
      if (w_rdata_we)
        r_rdata <= w_ld_data;
      if (w_wb_we)
        r_wb <= w_wb_nxt;
      if (w_err_set)
        r_err <= 1'b1;
    end
  end

  assign branchTarget = w_alu;
  assign memError     = r_err;
  assign memWb        = r_wb;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven IDLE vectors plus hand-written
// multi-cycle sequences, MEM/WB words checked through a queue.
module tb_mem_stage;

  localparam int N    = 24;
  localparam int BW   = 16 + 2 * N;
  localparam int WB_W = 6 + 2 * N;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en = 1'b0;
  logic            flush = 1'b0;
  logic [BW-1:0]   exMem = '0;
  logic [N-1:0]    memRdata = '0;
  logic            memAck = 1'b0;
  logic            memReq;
  logic            memWe;
  logic [N-1:0]    memAddr;
  logic [N-1:0]    memWdata;
  logic            stall;
  logic            branchTaken;
  logic [N-1:0]    branchTarget;
  logic            memError;
  logic [WB_W-1:0] memWb;

  mem_stage #(.N(N), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .exMem(exMem), .memRdata(memRdata), .memAck(memAck),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
    .memWdata(memWdata), .stall(stall),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .memError(memError), .memWb(memWb)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [WB_W-1:0] sbq[$];

  typedef struct {
    logic            fl;
    logic [1:0]      opc;
    logic            z;
    logic            ng;
    logic            bf;
    logic            mtr;
    logic            rw;
    logic [N-1:0]    alu;
    logic [3:0]      rc;
    logic            ebt;
    logic            est;
    logic [WB_W-1:0] ewb;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [BW-1:0] mk(
    input logic [3:0] opc, input logic z, input logic ng,
    input logic bf, input logic mw, input logic mtr,
    input logic rw, input logic [N-1:0] alu,
    input logic [3:0] rc, input logic [N-1:0] rd3);
    return {2'b00, opc, z, ng, bf, mw, mtr, rw, alu, rc, rd3};
  endfunction

  function automatic logic [WB_W-1:0] wbw(
    input logic rw, input logic mtr, input logic [3:0] rc,
    input logic [N-1:0] rd, input logic [N-1:0] alu);
    return {rw, mtr, rc, rd, alu};
  endfunction

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic sb_chk(input string nm);
    logic [WB_W-1:0] e;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got %h expected <queue empty>", nm, memWb);
    end else begin
      e = sbq.pop_front();
      chk(nm, memWb, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, 2'd0, 0, 0, 0, 0, 1, 24'h00ABCD, 4'd5, 0, 0,
                wbw(1, 0, 4'd5, 24'h0, 24'h00ABCD)};
    tbl[1]  = '{0, 2'd1, 1, 0, 1, 0, 0, 24'h000100, 4'd1, 1, 0,
                wbw(0, 0, 4'd1, 24'h0, 24'h000100)};
    tbl[2]  = '{1, 2'd1, 1, 0, 1, 0, 1, 24'h000100, 4'd1, 0, 0,
                wbw(0, 0, 4'd1, 24'h0, 24'h000100)};
    tbl[3]  = '{0, 2'd0, 0, 0, 1, 0, 1, 24'h000200, 4'd2, 1, 0,
                wbw(1, 0, 4'd2, 24'h0, 24'h000200)};
    tbl[4]  = '{0, 2'd2, 1, 0, 1, 0, 0, 24'h000300, 4'd3, 0, 0,
                wbw(0, 0, 4'd3, 24'h0, 24'h000300)};
    tbl[5]  = '{0, 2'd2, 0, 0, 1, 0, 0, 24'h000304, 4'd4, 1, 0,
                wbw(0, 0, 4'd4, 24'h0, 24'h000304)};
    tbl[6]  = '{0, 2'd3, 0, 1, 1, 0, 1, 24'hFFFFF0, 4'd6, 1, 0,
                wbw(1, 0, 4'd6, 24'h0, 24'hFFFFF0)};
    tbl[7]  = '{0, 2'd3, 1, 0, 1, 0, 0, 24'h000400, 4'd7, 0, 0,
                wbw(0, 0, 4'd7, 24'h0, 24'h000400)};
    tbl[8]  = '{0, 2'd1, 0, 0, 1, 0, 0, 24'h000500, 4'd8, 0, 0,
                wbw(0, 0, 4'd8, 24'h0, 24'h000500)};
    tbl[9]  = '{0, 2'd1, 1, 0, 0, 0, 1, 24'h000600, 4'hF, 0, 0,
                wbw(1, 0, 4'hF, 24'h0, 24'h000600)};
    tbl[10] = '{1, 2'd0, 0, 0, 0, 1, 1, 24'h000040, 4'hA, 0, 0,
                wbw(0, 0, 4'hA, 24'h0, 24'h000040)};

    // reset state
    tick();
    tick();
    chk("rst_wb", memWb, 0);
    chk("rst_err", memError, 0);
    chk("rst_req", memReq, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b1;
    tick();

    // single-cycle IDLE vectors
    for (int i = 0; i < 11; i++) begin
      exMem = mk({2'b00, tbl[i].opc}, tbl[i].z, tbl[i].ng,
                 tbl[i].bf, 1'b0, tbl[i].mtr, tbl[i].rw,
                 tbl[i].alu, tbl[i].rc, 24'h5A5A5A);
      flush = tbl[i].fl;
      en = 1'b1;
      sbq.push_back(tbl[i].ewb);
      #1;
      chk($sformatf("v%0d_bt", i), branchTaken, tbl[i].ebt);
      chk($sformatf("v%0d_tgt", i), branchTarget, tbl[i].alu);
      chk($sformatf("v%0d_stall", i), stall, tbl[i].est);
      chk($sformatf("v%0d_req", i), memReq, 0);
      tick();
      sb_chk($sformatf("v%0d_wb", i));
    end
    flush = 1'b0;

    // load, ack on third ACCESS cycle
    exMem = mk(4'd0, 0, 0, 0, 0, 1, 1, 24'h000040, 4'd3, 24'h0);
    #1;
    chk("ld_stall0", stall, 1);
    chk("ld_req0", memReq, 0);
    sbq.push_back('0);
    tick();
    sb_chk("ld_bubble");
    for (int c = 1; c <= 3; c++) begin
      if (c == 2)
        exMem = mk(4'd0, 0, 0, 0, 0, 0, 0, 24'h000999, 4'd0, 24'h0);
      memAck = (c == 3);
      memRdata = (c == 3) ? 24'h123456 : 24'h0;
      #1;
      chk($sformatf("ld_req%0d", c), memReq, 1);
      chk($sformatf("ld_addr%0d", c), memAddr, 24'h000040);
      chk($sformatf("ld_stall%0d", c), stall, (c != 3));
      tick();
    end
    memAck = 1'b0;
    sbq.push_back(wbw(1, 1, 4'd3, 24'h123456, 24'h000040));
    sb_chk("ld_wb");
    chk("ld_req_done", memReq, 0);
    chk("ld_stall_done", stall, 0);
    sbq.push_back(wbw(0, 0, 4'd0, 24'h0, 24'h000999));
    tick();
    sb_chk("ld_next_wb");

    // store, ack while en=0, release at cycle 5
    exMem = mk(4'd0, 0, 0, 0, 1, 0, 0, 24'h000080, 4'd0, 24'h0000FF);
    sbq.push_back('0);
    tick();
    sb_chk("st_bubble");
    #1;
    chk("st_we", memWe, 1);
    chk("st_wdata", memWdata, 24'h0000FF);
    chk("st_addr", memAddr, 24'h000080);
    chk("st_req1", memReq, 1);
    tick();
    en = 1'b0;
    memAck = 1'b1;
    memRdata = 24'hAAAAAA;
    #1;
    chk("st_req2", memReq, 1);
    chk("st_stall2", stall, 1);
    tick();
    memAck = 1'b1;
    memRdata = 24'hBBBBBB;
    #1;
    chk("st_done_req", memReq, 0);
    chk("st_done_stall", stall, 1);
    chk("st_done_wb", memWb, 0);
    tick();
    memAck = 1'b0;
    #1;
    chk("st_done_stall4", stall, 1);
    tick();
    en = 1'b1;
    exMem = '0;
    #1;
    chk("st_rel_stall", stall, 0);
    sbq.push_back(wbw(0, 0, 4'd0, 24'h0, 24'h000080));
    tick();
    sb_chk("st_wb");
    chk("st_idle_req", memReq, 0);

    // flush during ACCESS squashes the write-back
    exMem = mk(4'd0, 0, 0, 0, 0, 1, 1, 24'h000044, 4'd2, 24'h0);
    tick();
    flush = 1'b1;
    #1;
    chk("fl_req1", memReq, 1);
    tick();
    flush = 1'b0;
    exMem = mk(4'd0, 0, 0, 1, 0, 0, 0, 24'h000123, 4'd0, 24'h0);
    memAck = 1'b1;
    memRdata = 24'h777777;
    #1;
    chk("fl_req2", memReq, 1);
    chk("fl_bt_forced", branchTaken, 0);
    tick();
    memAck = 1'b0;
    chk("fl_wb", memWb, 0);
    chk("fl_idle_bt", branchTaken, 1);
    exMem = '0;
    tick();

    // timeout
    chk("to_err0", memError, 0);
    exMem = mk(4'd0, 0, 0, 0, 0, 1, 1, 24'h000055, 4'd7, 24'h0);
    tick();
    exMem = '0;
    for (int c = 1; c <= 15; c++) begin
      #1;
      chk($sformatf("to_req%0d", c), memReq, 1);
      chk($sformatf("to_err%0d", c), memError, 0);
      tick();
    end
    chk("to_err", memError, 1);
    chk("to_wb", memWb, 0);
    chk("to_req", memReq, 0);
    chk("to_stall", stall, 0);
    tick();
    tick();
    chk("to_sticky", memError, 1);

    // en=0 holds memWb in IDLE
    en = 1'b0;
    exMem = mk(4'd0, 0, 0, 0, 0, 0, 1, 24'h000321, 4'd9, 24'h0);
    tick();
    chk("hold_wb", memWb, 0);
    en = 1'b1;
    sbq.push_back(wbw(1, 0, 4'd9, 24'h0, 24'h000321));
    tick();
    sb_chk("hold_rel_wb");
    chk("hold_err", memError, 1);

    // async reset mid-ACCESS
    exMem = mk(4'd0, 0, 0, 0, 0, 1, 1, 24'h000060, 4'd1, 24'h0);
    tick();
    exMem = '0;
    #1;
    chk("ra_req_pre", memReq, 1);
    rst = 1'b0;
    #1;
    chk("ra_req", memReq, 0);
    chk("ra_wb", memWb, 0);
    chk("ra_err", memError, 0);
    tick();
    rst = 1'b1;
    #1;
    chk("ra_idle_req", memReq, 0);
    chk("ra_idle_stall", stall, 0);
    exMem = mk(4'd0, 0, 0, 0, 0, 0, 1, 24'h000777, 4'd4, 24'h0);
    sbq.push_back(wbw(1, 0, 4'd4, 24'h0, 24'h000777));
    tick();
    sb_chk("ra_alu_wb");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
